sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_pkg.sv | 29 ++
 rtl/sram_wait_cnt.sv | 33 +++
 rtl/sram_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared state type, timing defaults and counter sizing for the async SRAM controller.
// Burst reads are enabled in sram_ctrl by defining SRAM_CTRL_BURST_EN.
package sram_pkg;

    localparam int unsigned ADDR_W_DEF   = 17;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned RD_WAIT_DEF  = 2;
    localparam int unsigned WR_WAIT_DEF  = 2;
    localparam int unsigned TURN_CYC_DEF = 1;

    // Wide enough for the largest legal wait (15 cycles).
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LEN_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        TURN,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } sram_state_e;

    // The counter signals done on its last cycle, so a wait of N loads N-1.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Down-counter timing one wait phase; done_o is high in the final cycle of the phase.
module sram_wait_cnt
    import sram_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: single-request read/write sequencer with read turnaround.
// Define SRAM_CTRL_BURST_EN to add the req_len port and multi-beat reads.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RD_WAIT  = RD_WAIT_DEF,
    parameter int unsigned WR_WAIT  = WR_WAIT_DEF,
    parameter int unsigned TURN_CYC = TURN_CYC_DEF
) (
    input  logic              sysclk,
    input  logic              btn_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef SRAM_CTRL_BURST_EN
    input  logic [LEN_W-1:0]  req_len,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              nce,
    output logic              noe,
    output logic              nwe,
    inout  wire  [DATA_W-1:0] data_io
);

    sram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              drive;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_done;
    logic              more_beats;

`ifdef SRAM_CTRL_BURST_EN
    logic [LEN_W-1:0]  beats_q, beats_d;

    assign more_beats = (beats_q != '0);
`else
    assign more_beats = 1'b0;
`endif

    sram_wait_cnt u_wait_cnt (
        .clk_i      (sysclk),
        .rst_i      (btn_rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = '0;
`ifdef SRAM_CTRL_BURST_EN
        beats_d     = beats_q;
`endif
        nce         = 1'b1;
        noe         = 1'b1;
        nwe         = 1'b1;
        drive       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_we) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d  = RD_ACC;
                        cnt_load = 1'b1;
                        cnt_val  = wait_load(RD_WAIT);
`ifdef SRAM_CTRL_BURST_EN
                        beats_d  = req_len;
`endif
                    end
                end
            end
            RD_ACC: begin
                nce = 1'b0;
                noe = 1'b0;
                if (cnt_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = data_io;
                    cnt_load    = 1'b1;
                    // Further beats keep noe low and only advance the address.
                    if (more_beats) begin
                        addr_d  = addr_q + 1'b1;
                        cnt_val = wait_load(RD_WAIT);
`ifdef SRAM_CTRL_BURST_EN
                        beats_d = beats_q - 1'b1;
`endif
                    end else begin
                        state_d = TURN;
                        cnt_val = wait_load(TURN_CYC);
                    end
                end
            end
            TURN: begin
                if (cnt_done) begin
                    state_d = IDLE;
                end
            end
            WR_SETUP: begin
                nce      = 1'b0;
                drive    = 1'b1;
                state_d  = WR_PULSE;
                cnt_load = 1'b1;
                cnt_val  = wait_load(WR_WAIT);
            end
            WR_PULSE: begin
                nce   = 1'b0;
                nwe   = 1'b0;
                drive = 1'b1;
                if (cnt_done) begin
                    state_d = WR_HOLD;
                end
            end
            WR_HOLD: begin
                nce     = 1'b0;
                drive   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge btn_rst) begin
        if (btn_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
`ifdef SRAM_CTRL_BURST_EN
            beats_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef SRAM_CTRL_BURST_EN
            beats_q     <= beats_d;
`endif
        end
    end

    // Reset gates ready directly so it stays low for the whole reset pulse.
    assign req_ready = (state_q == IDLE) && !btn_rst;
    assign busy      = (state_q != IDLE);
    assign addr      = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign data_io   = drive ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural SRAM on the bus plus a cycle-indexed
// expectation model of each access; burst checks are included when SRAM_CTRL_BURST_EN is defined.
module tb_sram_ctrl;

    localparam int unsigned AW  = 17;
    localparam int unsigned DW  = 8;
    localparam int unsigned RDW = 2;
    localparam int unsigned WRW = 2;
    localparam int unsigned TC  = 1;

    logic          sysclk = 1'b0;
    logic          btn_rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [7:0]    req_len;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic [AW-1:0] addr;
    logic          nce;
    logic          noe;
    logic          nwe;
    tri1  [DW-1:0] data_io;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          mon_en = 1'b0;

    localparam logic [DW-1:0] RELEASED = {DW{1'b1}};

    always #5 sysclk = ~sysclk;

    sram_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RD_WAIT  (RDW),
        .WR_WAIT  (WRW),
        .TURN_CYC (TC)
    ) dut (
        .sysclk    (sysclk),
        .btn_rst   (btn_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef SRAM_CTRL_BURST_EN
        .req_len   (req_len),
`endif
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .addr      (addr),
        .nce       (nce),
        .noe       (noe),
        .nwe       (nwe),
        .data_io   (data_io)
    );

    // Behavioural asynchronous SRAM.
    assign data_io = (!nce && !noe) ? mem[addr] : 'z;

    always @(negedge sysclk) begin
        if (!nce && !nwe) mem[addr] = data_io;
    end

    // Bus-level invariants checked on every cycle.
    always @(negedge sysclk) begin
        if (mon_en) begin
            total++;
            if (!noe && !nwe) begin
                bad++;
                $display("FAIL bus_excl t=%0t noe=%b nwe=%b (never both low)", $time, noe, nwe);
            end
            total++;
            if (nce && (nwe !== 1'b1 || noe !== 1'b1 || data_io !== RELEASED)) begin
                bad++;
                $display("FAIL bus_idle t=%0t nwe=%b noe=%b data_io=%h want 1/1/released", $time, nwe, noe, data_io);
            end
            total++;
            if (!nce && !noe && data_io !== mem[addr]) begin
                bad++;
                $display("FAIL bus_rd_contention t=%0t data_io=%h want %h", $time, data_io, mem[addr]);
            end
        end
    end

    function automatic logic [DW-1:0] rand_wdata();
        return DW'($urandom_range(0, (1 << DW) - 2));
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge sysclk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout req_ready=%b want 1 within 64 cycles", req_ready);
        end
    endtask

    task automatic scramble_req();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        req_len   = 8'($urandom);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int unsigned len);
        int unsigned   beats;
        int unsigned   last;
        bit            ok;
        bit            exp_v;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        req_we    = 1'b0;
        req_addr  = a;
        req_len   = 8'(len);
        req_wdata = DW'($urandom);
        req_valid = 1'b1;
`ifdef SRAM_CTRL_BURST_EN
        beats = int'(req_len) + 1;
`else
        beats = (req_len == 8'hFF) ? 1 : 1;
`endif
        wait_ready(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge sysclk);
        #1 scramble_req();
        last = beats * RDW + TC + 1;
        for (int unsigned i = 1; i <= last; i++) begin
            @(negedge sysclk);
            total++;
            if (i <= beats * RDW) begin
                ea = a + AW'((i - 1) / RDW);
                if (nce !== 1'b0 || noe !== 1'b0 || nwe !== 1'b1 || addr !== ea || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL rd_access i=%0d nce=%b noe=%b nwe=%b busy=%b addr=%h want 0/0/1/1 addr=%h", i, nce, noe, nwe, busy, addr, ea);
                end
            end else if (i < last) begin
                if (nce !== 1'b1 || noe !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL rd_turn i=%0d nce=%b noe=%b ready=%b busy=%b want 1/1/0/1", i, nce, noe, req_ready, busy);
                end
            end else begin
                if (req_ready !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_idle i=%0d ready=%b busy=%b want 1/0", i, req_ready, busy);
                end
            end
            exp_v = (i > RDW) && ((i - 1) % RDW == 0) && (i <= beats * RDW + 1);
            total++;
            if (rsp_valid !== exp_v) begin
                bad++;
                $display("FAIL rd_valid i=%0d rsp_valid=%b want %b", i, rsp_valid, exp_v);
            end
            if (exp_v) begin
                ea = a + AW'((i - 1) / RDW - 1);
                ed = ref_mem[ea];
                total++;
                if (rsp_data !== ed) begin
                    bad++;
                    $display("FAIL rd_data i=%0d addr=%h rsp_data=%h want %h", i, ea, rsp_data, ed);
                end
            end
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] len);
        bit ok;
        bit exp_nwe;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_len   = len;
        req_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        ref_mem[a] = d;
        @(posedge sysclk);
        #1 scramble_req();
        for (int unsigned i = 1; i <= WRW + 3; i++) begin
            @(negedge sysclk);
            total++;
            if (i <= WRW + 2) begin
                exp_nwe = (i == 1 || i == WRW + 2);
                if (nce !== 1'b0 || noe !== 1'b1 || nwe !== exp_nwe || addr !== a || data_io !== d || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL wr_access i=%0d nce=%b noe=%b nwe=%b addr=%h data_io=%h want 0/1/%b addr=%h data=%h", i, nce, noe, nwe, addr, data_io, exp_nwe, a, d);
                end
            end else begin
                if (nce !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || data_io !== RELEASED) begin
                    bad++;
                    $display("FAIL wr_idle nce=%b ready=%b busy=%b data_io=%h want 1/1/0/released", nce, req_ready, busy, data_io);
                end
            end
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL wr_rsp i=%0d rsp_valid=%b want 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_reset();
        btn_rst = 1'b1;
        scramble_req();
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            mon_en = 1'b1;
            total++;
            if (nce !== 1'b1 || noe !== 1'b1 || nwe !== 1'b1 || data_io !== RELEASED || addr !== '0 ||
                rsp_valid !== 1'b0 || rsp_data !== '0 || busy !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold nce=%b noe=%b nwe=%b data=%h addr=%h rv=%b rd=%h busy=%b ready=%b", nce, noe, nwe, data_io, addr, rsp_valid, rsp_data, busy, req_ready);
            end
        end
        btn_rst = 1'b0;
        @(negedge sysclk);
        total++;
        if (req_ready !== 1'b1 || nce !== 1'b1 || noe !== 1'b1 || nwe !== 1'b1 || data_io !== RELEASED) begin
            bad++;
            $display("FAIL reset_release ready=%b nce=%b noe=%b nwe=%b data=%h want 1/1/1/1/released", req_ready, nce, noe, nwe, data_io);
        end
    endtask

    task automatic test_write_read();
        do_write(17'h1A5F, 8'hC3, 8'h00);
        do_read(17'h1A5F, 0);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            ok;
        bit            drop;
        bit            prev_ok;
        int unsigned   first_drive;
        ra = AW'($urandom);
        wa = AW'($urandom);
        wd = rand_wdata();
        req_we    = 1'b0;
        req_addr  = ra;
        req_len   = 8'h00;
        req_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge sysclk);
        #1;
        req_we    = 1'b1;
        req_addr  = wa;
        req_wdata = wd;
        drop        = 1'b0;
        prev_ok     = 1'b0;
        first_drive = 0;
        for (int unsigned i = 1; i <= RDW + TC + WRW + 4; i++) begin
            @(negedge sysclk);
            if (drop) begin
                scramble_req();
                drop = 1'b0;
            end
            if (i == RDW + 1) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[ra]) begin
                    bad++;
                    $display("FAIL b2b_rd_data rsp_valid=%b rsp_data=%h want 1/%h", rsp_valid, rsp_data, ref_mem[ra]);
                end
            end
            if (first_drive == 0 && noe === 1'b1 && data_io !== RELEASED) begin
                first_drive = i;
                total++;
                if (!prev_ok || i != RDW + TC + 2) begin
                    bad++;
                    $display("FAIL b2b_turn first_drive=%0d turn_seen=%b want cycle %0d after a released noe-high cycle", i, prev_ok, RDW + TC + 2);
                end
            end
            prev_ok = (noe === 1'b1) && (nce === 1'b1) && (data_io === RELEASED);
            if (req_valid && req_ready === 1'b1) begin
                ref_mem[wa] = wd;
                drop = 1'b1;
            end
        end
        req_valid = 1'b0;
        if (first_drive == 0) begin
            total++;
            bad++;
            $display("FAIL b2b_no_write data_io never driven, want drive at cycle %0d", RDW + TC + 2);
        end
        do_read(wa, 0);
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            ok;
        bit            seen;
        a = AW'($urandom);
        d = rand_wdata();
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge sysclk);
        #1 scramble_req();
        seen = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(negedge sysclk);
            if (nwe === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rstmid_no_pulse nwe=%b want 0 within 16 cycles", nwe);
        end
        ref_mem[a] = d;
        #2 btn_rst = 1'b1;
        #1;
        total++;
        if (nwe !== 1'b1 || nce !== 1'b1 || noe !== 1'b1 || data_io !== RELEASED || busy !== 1'b0 ||
            req_ready !== 1'b0 || rsp_valid !== 1'b0 || addr !== '0) begin
            bad++;
            $display("FAIL rstmid_release nwe=%b nce=%b noe=%b data=%h busy=%b ready=%b rv=%b addr=%h", nwe, nce, noe, data_io, busy, req_ready, rsp_valid, addr);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge sysclk);
            total++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_hold rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
            end
        end
        btn_rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge sysclk);
            total++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_after rsp_valid=%b ready=%b want 0/1", rsp_valid, req_ready);
            end
        end
        do_read(a, 0);
    endtask

`ifdef SRAM_CTRL_BURST_EN
    task automatic test_burst();
        do_write(17'h1FFFF, rand_wdata(), 8'h05);
        do_write(17'h00000, rand_wdata(), 8'h03);
        do_read(17'h1FFFE, 3);
        do_read(AW'($urandom), $urandom_range(0, 5));
    endtask
`endif

    task automatic test_random();
        logic [AW-1:0] pool [8];
        logic [AW-1:0] a;
        foreach (pool[k]) pool[k] = AW'($urandom);
        for (int n = 0; n < 40; n++) begin
            a = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, rand_wdata(), 8'($urandom));
            end else begin
                do_read(a, $urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'((i * 37) ^ (i >> 8));
            ref_mem[i] = DW'((i * 37) ^ (i >> 8));
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_reset_mid();
`ifdef SRAM_CTRL_BURST_EN
        test_burst();
`endif
        test_random();
        repeat (3) @(negedge sysclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
